// File: rtl/sie_bus_irq_ctrl.sv
// sie_bus_irq_ctrl: bridges the CPU's asynchronous SRAM-style bus to up to
// NPER FPGA peripherals and hosts a small edge-triggered interrupt unit.
// Bus strobes are synchronised. Each chip-select low period gives one
// single-cycle read or write strobe to the addressed peripheral. Window 3 of
// the address map holds this block's own PEND/MASK/ID/STAT registers.
module sie_bus_irq_ctrl #(
  parameter int B    = 7,
  parameter int NPER = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [12:0]           addr_i,
  input  logic                  ncs_i,
  input  logic                  noe_i,
  input  logic                  nwe_i,
  inout  wire  [B:0]            sram_data_io,
  output logic [NPER-1:0]       per_cs_o,
  output logic [10:0]           per_addr_o,
  output logic [NPER-1:0]       per_rd_o,
  output logic [NPER-1:0]       per_wr_o,
  output logic [B:0]            per_wdata_o,
  input  logic [NPER*(B+1)-1:0] per_rdata_i,
  input  logic [NPER-1:0]       irq_in_i,
  output logic                  irq_o
);

  localparam int W = B + 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DECODE  = 4'd1,
    READ    = 4'd2,
    WR_WAIT = 4'd3,
    WRITE   = 4'd4,
    HOLD    = 4'd5
  } state_e;

  state_e          state_q, state_d;
  logic            ncs_meta_q, ncs_sync_q;
  logic            noe_meta_q, noe_sync_q;
  logic            nwe_meta_q, nwe_sync_q;
  logic [NPER-1:0] irq_meta_q, irq_sync_q, irq_prev_q;
  logic [12:0]     addr_q;
  logic [B:0]      data_q;
  logic            armed_q, armed_d;
  logic [1:0]      window_q, window_d;
  logic [10:0]     per_addr_q, per_addr_d;
  logic [NPER-1:0] per_cs_q, per_cs_d;
  logic [B:0]      per_wdata_q, per_wdata_d;
  logic [B:0]      rdata_q, rdata_d;
  logic [NPER-1:0] pend_q, pend_d;
  logic [NPER-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;
  logic [NPER-1:0] winOneHot;
  logic [NPER-1:0] irqRise;
  logic [7:0]      localRd;
  logic [B:0]      readSel;

  // Synchronisers and input capture. The ncs chain resets to "selected" so
  // that a CPU still holding ncs low after reset does not look like a fresh
  // access; noe/nwe reset to their inactive level.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ncs_meta_q <= 1'b0;
      ncs_sync_q <= 1'b0;
      noe_meta_q <= 1'b1;
      noe_sync_q <= 1'b1;
      nwe_meta_q <= 1'b1;
      nwe_sync_q <= 1'b1;
      irq_meta_q <= '0;
      irq_sync_q <= '0;
      irq_prev_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      ncs_meta_q <= ncs_i;
      ncs_sync_q <= ncs_meta_q;
      noe_meta_q <= noe_i;
      noe_sync_q <= noe_meta_q;
      nwe_meta_q <= nwe_i;
      nwe_sync_q <= nwe_meta_q;
      irq_meta_q <= irq_in_i;
      irq_sync_q <= irq_meta_q;
      irq_prev_q <= irq_sync_q;
      addr_q     <= addr_i;
      data_q     <= sram_data_io;
    end
  end

  // One-hot select of the latched window; window 3 and unpopulated windows map to no peripheral.
  always_comb begin
    winOneHot = '0;
    for (int i = 0; i < NPER; i++) begin
      winOneHot[i] = (window_q == 2'(i));
    end
  end

  // Local register read mux; ID scans downwards so the lowest pending enabled bit wins.
  always_comb begin
    localRd = '0;
    case (per_addr_q[1:0])
      2'd0: localRd[NPER-1:0] = pend_q;
      2'd1: localRd[NPER-1:0] = mask_q;
      2'd2: begin
        localRd = 8'hFF;
        for (int i = NPER - 1; i >= 0; i--) begin
          if (pend_q[i] && mask_q[i]) localRd = 8'(i);
        end
      end
      default: localRd = {irq_q, 3'b000, state_q};
    endcase
  end

  // Read data source: local registers, a peripheral slice, or zero for an empty window.
  always_comb begin
    readSel = '0;
    if (window_q == 2'd3) begin
      readSel = W'(localRd);
    end else begin
      for (int i = 0; i < NPER; i++) begin
        if (window_q == 2'(i)) readSel = per_rdata_i[i*W +: W];
      end
    end
  end

  assign irqRise = irq_sync_q & ~irq_prev_q;

  // Bus FSM next state plus the interrupt unit; a new irq edge always survives a same-cycle W1C.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    window_d    = window_q;
    per_addr_d  = per_addr_q;
    per_cs_d    = per_cs_q;
    per_wdata_d = per_wdata_q;
    rdata_d     = rdata_q;
    pend_d      = pend_q | irqRise;
    mask_d      = mask_q;
    irq_d       = |(pend_q & mask_q);
    if (ncs_sync_q) armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        per_cs_d = '0;
        if (!ncs_sync_q && armed_q) begin
          state_d    = DECODE;
          per_addr_d = addr_q[10:0];
          window_d   = addr_q[12:11];
        end
      end
      DECODE: begin
        if (ncs_sync_q) begin
          state_d  = IDLE;
          per_cs_d = '0;
        end else begin
          per_cs_d = winOneHot;
          if (!noe_sync_q)      state_d = READ;
          else if (!nwe_sync_q) state_d = WR_WAIT;
        end
      end
      READ: begin
        rdata_d = readSel;
        state_d = HOLD;
      end
      WR_WAIT: begin
        if (nwe_sync_q || ncs_sync_q) state_d = WRITE;
        else                          per_wdata_d = data_q;
      end
      WRITE: begin
        if (window_q == 2'd3) begin
          if (per_addr_q[1:0] == 2'd0) pend_d = (pend_q & ~per_wdata_q[NPER-1:0]) | irqRise;
          if (per_addr_q[1:0] == 2'd1) mask_d = per_wdata_q[NPER-1:0];
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (ncs_sync_q) begin
          state_d  = IDLE;
          per_cs_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also drops any access in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      window_q    <= '0;
      per_addr_q  <= '0;
      per_cs_q    <= '0;
      per_wdata_q <= '0;
      rdata_q     <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      window_q    <= window_d;
      per_addr_q  <= per_addr_d;
      per_cs_q    <= per_cs_d;
      per_wdata_q <= per_wdata_d;
      rdata_q     <= rdata_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      irq_q       <= irq_d;
    end
  end

  assign per_cs_o    = per_cs_q;
  assign per_addr_o  = per_addr_q;
  assign per_wdata_o = per_wdata_q;
  assign per_rd_o    = (state_q == READ)  ? winOneHot : '0;
  assign per_wr_o    = (state_q == WRITE) ? winOneHot : '0;
  assign irq_o       = irq_q;

  assign sram_data_io = (!ncs_i && !noe_i && reset_i) ? rdata_q : 'z;

endmodule
